// File: rtl/mem_pkg.sv
// Shared constants and FSM state encoding for the memory interface stage.
// Imported by the RAM macro and the MAR/MDR/FSM top level.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 9;
  localparam int MEM_DEPTH      = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HOLD    = 2'd2
  } mem_state_t;

endpackage : mem_pkg

// File: rtl/ram_512x32.sv
// Single-port synchronous RAM with a registered read address.
// The controlling FSM guarantees a read and a write never share an edge.
module ram_512x32
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  // NOTE: the array and its read address carry no reset, so the storage maps
  // onto a RAM macro; contents survive a reset of the surrounding logic.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rd_addr <= i_addr;
    end
  end

  assign o_rdata = r_mem[r_rd_addr];

endmodule : ram_512x32

// File: rtl/memory_interface.sv
// Memory-side datapath stage: MAR, MDR, 512x32 RAM and a small access FSM
// returning a one-cycle MemReady pulse per access.
module memory_interface
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  Write,
  output logic [DATA_WIDTH-1:0] MAR_q,
  output logic [DATA_WIDTH-1:0] MDR_q,
  output logic                  MemReady,
  output logic                  MemBusy
);

  mem_state_t            r_state;
  mem_state_t            w_state_next;
  logic [DATA_WIDTH-1:0] r_mar;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic                  r_ready;

  logic                  w_ram_we;
  logic                  w_ram_re;
  logic                  w_mdr_load_bus;
  logic                  w_mdr_load_ram;
  logic                  w_ready_next;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Upper MAR bits are ignored, so addresses alias modulo DEPTH.
  assign w_ram_addr = r_mar[ADDR_WIDTH-1:0];

  ram_512x32 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_clk   (Clock),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (r_mdr),
    .o_rdata (w_ram_rdata)
  );

  // NOTE: every output of this block is given a default before the case
  // statement, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_ram_we       = 1'b0;
    w_ram_re       = 1'b0;
    w_mdr_load_bus = 1'b0;
    w_mdr_load_ram = 1'b0;
    w_ready_next   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Write) begin
          w_ram_we     = 1'b1;
          w_ready_next = 1'b1;
          w_state_next = HOLD;
        end else if (Read) begin
          w_ram_re     = 1'b1;
          w_state_next = RD_WAIT;
        end else if (MDRin) begin
          w_mdr_load_bus = 1'b1;
        end
      end
      RD_WAIT: begin
        w_mdr_load_ram = MDRin;
        w_ready_next   = 1'b1;
        w_state_next   = HOLD;
      end
      HOLD: begin
        // Wait for both strobes to drop so a held strobe cannot re-trigger.
        if (!Read && !Write) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= w_ready_next;
      if (MARin) begin
        r_mar <= BusMuxOut;
      end
      if (w_mdr_load_ram) begin
        r_mdr <= w_ram_rdata;
      end else if (w_mdr_load_bus) begin
        r_mdr <= BusMuxOut;
      end
    end
  end

  assign MAR_q    = r_mar;
  assign MDR_q    = r_mdr;
  assign MemReady = r_ready;
  assign MemBusy  = (r_state != IDLE);

endmodule : memory_interface

// File: tb/tb_memory_interface.sv
// Directed, table-driven bench for memory_interface plus hand-written
// sequences for reset during a read and a long-held Read strobe.
module tb_memory_interface;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [31:0] MAR_q, MDR_q;
  logic        MemReady, MemBusy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] bus;
    logic        marin;
    logic        mdrin;
    logic        rd;
    logic        wr;
    logic [31:0] exp_mar;
    logic [31:0] exp_mdr;
    logic        exp_ready;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  memory_interface dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .MAR_q     (MAR_q),
    .MDR_q     (MDR_q),
    .MemReady  (MemReady),
    .MemBusy   (MemBusy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] bus, input logic marin, input logic mdrin,
                     input logic rd, input logic wr, input logic [31:0] emar,
                     input logic [31:0] emdr, input logic erdy, input logic ebusy);
    vec_t v;
    v.bus = bus; v.marin = marin; v.mdrin = mdrin; v.rd = rd; v.wr = wr;
    v.exp_mar = emar; v.exp_mdr = emdr; v.exp_ready = erdy; v.exp_busy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] bus, input logic marin, input logic mdrin,
                       input logic rd, input logic wr);
    BusMuxOut = bus; MARin = marin; MDRin = mdrin; Read = rd; Write = wr;
  endtask

  initial begin
    int pulses;
    // Each row: inputs applied for one edge, outputs expected just after it.
    //   bus            MARin MDRin Rd Wr  MAR            MDR            Rdy Busy
    // write then read at 0x54
    add(32'h0000_0054, 1, 0, 0, 0, 32'h0000_0054, 32'h0000_0000, 0, 0);
    add(32'h1234_ABCD, 0, 1, 0, 0, 32'h0000_0054, 32'h1234_ABCD, 0, 0);
    add(32'h0000_0000, 0, 0, 0, 1, 32'h0000_0054, 32'h1234_ABCD, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0054, 32'h1234_ABCD, 0, 0);
    add(32'h0000_0000, 0, 1, 0, 0, 32'h0000_0054, 32'h0000_0000, 0, 0);
    add(32'h0000_0000, 0, 1, 1, 0, 32'h0000_0054, 32'h0000_0000, 0, 1);
    add(32'h0000_0000, 0, 1, 1, 0, 32'h0000_0054, 32'h1234_ABCD, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0054, 32'h1234_ABCD, 0, 0);
    // aliasing: 0x203 and 0x003 share a RAM word
    add(32'h0000_0203, 1, 0, 0, 0, 32'h0000_0203, 32'h1234_ABCD, 0, 0);
    add(32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0000_0203, 32'hDEAD_BEEF, 0, 0);
    add(32'h0000_0000, 0, 0, 0, 1, 32'h0000_0203, 32'hDEAD_BEEF, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0203, 32'hDEAD_BEEF, 0, 0);
    add(32'h0000_0003, 1, 1, 0, 0, 32'h0000_0003, 32'h0000_0003, 0, 0);
    add(32'h0000_0000, 0, 1, 1, 0, 32'h0000_0003, 32'h0000_0003, 0, 1);
    add(32'h0000_0000, 0, 1, 0, 0, 32'h0000_0003, 32'hDEAD_BEEF, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0003, 32'hDEAD_BEEF, 0, 0);
    // Read+Write conflict at 0x10: write wins, bus load ignored
    add(32'h0000_0010, 1, 0, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
    add(32'h0000_0007, 0, 1, 0, 0, 32'h0000_0010, 32'h0000_0007, 0, 0);
    add(32'h0000_FFFF, 0, 1, 1, 1, 32'h0000_0010, 32'h0000_0007, 1, 1);
    add(32'h0000_FFFF, 0, 1, 1, 1, 32'h0000_0010, 32'h0000_0007, 0, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0010, 32'h0000_0007, 0, 0);
    add(32'h0000_0000, 0, 1, 0, 0, 32'h0000_0010, 32'h0000_0000, 0, 0);
    add(32'h0000_0000, 0, 1, 1, 0, 32'h0000_0010, 32'h0000_0000, 0, 1);
    add(32'h0000_0000, 0, 1, 0, 0, 32'h0000_0010, 32'h0000_0007, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0010, 32'h0000_0007, 0, 0);
    // MAR change during RD_WAIT: RAM[0x20]=AAAA0001, RAM[0x21]=0x21
    add(32'h0000_0020, 1, 0, 0, 0, 32'h0000_0020, 32'h0000_0007, 0, 0);
    add(32'hAAAA_0001, 0, 1, 0, 0, 32'h0000_0020, 32'hAAAA_0001, 0, 0);
    add(32'h0000_0000, 0, 0, 0, 1, 32'h0000_0020, 32'hAAAA_0001, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0020, 32'hAAAA_0001, 0, 0);
    add(32'h0000_0021, 1, 1, 0, 0, 32'h0000_0021, 32'h0000_0021, 0, 0);
    add(32'h0000_0000, 0, 0, 0, 1, 32'h0000_0021, 32'h0000_0021, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0021, 32'h0000_0021, 0, 0);
    add(32'h0000_0020, 1, 1, 0, 0, 32'h0000_0020, 32'h0000_0020, 0, 0);
    add(32'h0000_0000, 0, 1, 1, 0, 32'h0000_0020, 32'h0000_0020, 0, 1);
    add(32'h0000_0021, 1, 1, 0, 0, 32'h0000_0021, 32'hAAAA_0001, 1, 1);
    add(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0021, 32'hAAAA_0001, 0, 0);

    Reset = 1'b1;
    drive(32'h0, 0, 0, 0, 0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    check("reset MAR", MAR_q, 32'h0);
    check("reset MDR", MDR_q, 32'h0);
    check("reset MemReady", {31'b0, MemReady}, 32'h0);
    check("reset MemBusy", {31'b0, MemBusy}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].bus, vecs[i].marin, vecs[i].mdrin, vecs[i].rd, vecs[i].wr);
      @(posedge Clock);
      #1;
      check($sformatf("vec%0d MAR", i), MAR_q, vecs[i].exp_mar);
      check($sformatf("vec%0d MDR", i), MDR_q, vecs[i].exp_mdr);
      check($sformatf("vec%0d MemReady", i), {31'b0, MemReady}, {31'b0, vecs[i].exp_ready});
      check($sformatf("vec%0d MemBusy", i), {31'b0, MemBusy}, {31'b0, vecs[i].exp_busy});
    end

    // Reset between read issue and data return: MDR cleared, no pulse.
    drive(32'h0000_0054, 1, 1, 0, 0);
    @(posedge Clock); #1;
    check("pre-abort MDR", MDR_q, 32'h0000_0054);
    drive(32'h0, 0, 1, 1, 0);
    @(posedge Clock); #1;
    check("abort busy after issue", {31'b0, MemBusy}, 32'h1);
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    drive(32'h0, 0, 0, 0, 0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock); #1;
      if (MemReady) pulses++;
    end
    check("abort MDR", MDR_q, 32'h0);
    check("abort MemReady pulses", pulses, 0);
    check("abort MemBusy", {31'b0, MemBusy}, 32'h0);

    // Read held for 10 cycles at 0x54: one pulse, busy throughout.
    drive(32'h0000_0054, 1, 0, 0, 0);
    @(posedge Clock); #1;
    drive(32'h0, 0, 1, 1, 0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clock); #1;
      if (MemReady) pulses++;
      check($sformatf("held busy c%0d", c), {31'b0, MemBusy}, 32'h1);
    end
    check("held MemReady pulses", pulses, 1);
    check("held MDR", MDR_q, 32'h1234_ABCD);
    drive(32'h0, 0, 0, 0, 0);
    @(posedge Clock); #1;
    check("held release busy", {31'b0, MemBusy}, 32'h0);
    check("held release ready", {31'b0, MemReady}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_memory_interface
